// File: rtl/exec_sequencer_if.sv
// Signal bundle between the execute pipeline and its stall/flush sequencer.
// The master side is the pipeline; the slave side is exec_sequencer.
interface exec_sequencer_if;
    logic [5:0]  D_rs1Id_i;
    logic [5:0]  D_rs2Id_i;
    logic [5:0]  D_rs3Id_i;
    logic        D_rs1Used_i;
    logic        D_rs2Used_i;
    logic        D_rs3Used_i;
    logic        DE_isLoad_i;
    logic        DE_wbEnable_i;
    logic [5:0]  DE_rdId_i;
    logic        aluBusy_i;
    logic        E_correctPC_i;
    logic        halt_i;

    logic        F_stall_o;
    logic        D_stall_o;
    logic        E_stall_o;
    logic        D_flush_o;
    logic        E_flush_o;
    logic        M_flush_o;
    logic        dataHazard_o;
    logic [1:0]  state_o;
    logic        halted_o;
    logic        timeout_o;
    logic [31:0] stallCycles_o;
    logic [31:0] multiOps_o;

    modport master (
        output D_rs1Id_i, D_rs2Id_i, D_rs3Id_i,
        output D_rs1Used_i, D_rs2Used_i, D_rs3Used_i,
        output DE_isLoad_i, DE_wbEnable_i, DE_rdId_i,
        output aluBusy_i, E_correctPC_i, halt_i,
        input  F_stall_o, D_stall_o, E_stall_o,
        input  D_flush_o, E_flush_o, M_flush_o,
        input  dataHazard_o, state_o, halted_o, timeout_o,
        input  stallCycles_o, multiOps_o
    );

    modport slave (
        input  D_rs1Id_i, D_rs2Id_i, D_rs3Id_i,
        input  D_rs1Used_i, D_rs2Used_i, D_rs3Used_i,
        input  DE_isLoad_i, DE_wbEnable_i, DE_rdId_i,
        input  aluBusy_i, E_correctPC_i, halt_i,
        output F_stall_o, D_stall_o, E_stall_o,
        output D_flush_o, E_flush_o, M_flush_o,
        output dataHazard_o, state_o, halted_o, timeout_o,
        output stallCycles_o, multiOps_o
    );
endinterface

// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: turns load-use hazards, multi-cycle busy, branch
// correction and halt into per-stage stall/flush controls, with a watchdog.
module exec_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             reset_i,
    exec_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MULTI = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [15:0] wd_q, wd_d;
    logic        halted_q;
    logic        timeout_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] multi_cnt_q;

    logic        hazard;
    logic        run_rules;
    logic        timeout_set;
    logic        multi_done;
    logic        f_stall, d_stall, e_stall;
    logic        d_flush, e_flush, m_flush;

    always_comb begin
        hazard = bus.DE_isLoad_i && bus.DE_wbEnable_i && (bus.DE_rdId_i != 6'd0) &&
                 ((bus.D_rs1Used_i && (bus.D_rs1Id_i == bus.DE_rdId_i)) ||
                  (bus.D_rs2Used_i && (bus.D_rs2Id_i == bus.DE_rdId_i)) ||
                  (bus.D_rs3Used_i && (bus.D_rs3Id_i == bus.DE_rdId_i)));
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d     = state_q;
        wd_d        = wd_q;
        run_rules   = 1'b0;
        timeout_set = 1'b0;
        multi_done  = 1'b0;
        f_stall     = 1'b0;
        d_stall     = 1'b0;
        e_stall     = 1'b0;
        d_flush     = 1'b0;
        e_flush     = 1'b0;
        m_flush     = 1'b0;

        if (reset_i) begin
            d_flush = 1'b1;
            e_flush = 1'b1;
            m_flush = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.halt_i && !bus.aluBusy_i) begin
                        {f_stall, d_stall, e_stall, m_flush} = 4'b1111;
                        state_d = ST_HALT;
                    end else if (bus.aluBusy_i) begin
                        {f_stall, d_stall, e_stall, m_flush} = 4'b1111;
                        wd_d    = 16'd1;
                        state_d = ST_MULTI;
                    end else begin
                        run_rules = 1'b1;
                    end
                end
                ST_MULTI: begin
                    if (bus.aluBusy_i) begin
                        {f_stall, d_stall, e_stall, m_flush} = 4'b1111;
                        if (wd_q == TIMEOUT_W) begin
                            timeout_set = 1'b1;
                            state_d     = ST_HALT;
                        end else begin
                            wd_d = wd_q + 16'd1;
                        end
                    end else begin
                        // Result advances into EM now; halt_i waits for RUN.
                        multi_done = 1'b1;
                        run_rules  = 1'b1;
                        wd_d       = 16'd0;
                        state_d    = ST_RUN;
                    end
                end
                ST_HALT: begin
                    {f_stall, d_stall, e_stall, m_flush} = 4'b1111;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase

            // A correction squashes decode, so its hazard cannot stall.
            if (run_rules) begin
                if (bus.E_correctPC_i) begin
                    d_flush = 1'b1;
                    e_flush = 1'b1;
                end else if (hazard) begin
                    f_stall = 1'b1;
                    d_stall = 1'b1;
                    e_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset_i) begin
            state_q <= ST_RUN;
            wd_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= 32'd0;
            multi_cnt_q <= 32'd0;
        end else begin
            if (state_d == ST_HALT) halted_q    <= 1'b1;
            if (timeout_set)        timeout_q   <= 1'b1;
            if (e_stall)            stall_cnt_q <= stall_cnt_q + 32'd1;
            if (multi_done)         multi_cnt_q <= multi_cnt_q + 32'd1;
        end
    end

    assign bus.F_stall_o     = f_stall;
    assign bus.D_stall_o     = d_stall;
    assign bus.E_stall_o     = e_stall;
    assign bus.D_flush_o     = d_flush;
    assign bus.E_flush_o     = e_flush;
    assign bus.M_flush_o     = m_flush;
    assign bus.dataHazard_o  = hazard;
    assign bus.state_o       = state_q;
    assign bus.halted_o      = halted_q;
    assign bus.timeout_o     = timeout_q;
    assign bus.stallCycles_o = stall_cnt_q;
    assign bus.multiOps_o    = multi_cnt_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: hazards, multi-cycle ops, halt,
// watchdog, counter wrap and reset, with hand-computed expectations.
module tb_exec_sequencer;

    logic clk_i = 1'b0;
    logic reset_i;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk_i = ~clk_i;

    exec_sequencer_if bus ();
    exec_sequencer_if wbus ();

    exec_sequencer dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    exec_sequencer #(.TIMEOUT_CYCLES(8)) dut_wd (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (wbus.slave)
    );

    // {F_stall, D_stall, E_stall, D_flush, E_flush, M_flush, dataHazard}
    logic [6:0] ctl;
    assign ctl = {bus.F_stall_o, bus.D_stall_o, bus.E_stall_o,
                  bus.D_flush_o, bus.E_flush_o, bus.M_flush_o, bus.dataHazard_o};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.D_rs1Id_i = 6'd0;  bus.D_rs2Id_i = 6'd0;  bus.D_rs3Id_i = 6'd0;
        bus.D_rs1Used_i = 1'b0; bus.D_rs2Used_i = 1'b0; bus.D_rs3Used_i = 1'b0;
        bus.DE_isLoad_i = 1'b0; bus.DE_wbEnable_i = 1'b0; bus.DE_rdId_i = 6'd0;
        bus.aluBusy_i = 1'b0; bus.E_correctPC_i = 1'b0; bus.halt_i = 1'b0;
    endtask

    task automatic idle_wd();
        wbus.D_rs1Id_i = 6'd0;  wbus.D_rs2Id_i = 6'd0;  wbus.D_rs3Id_i = 6'd0;
        wbus.D_rs1Used_i = 1'b0; wbus.D_rs2Used_i = 1'b0; wbus.D_rs3Used_i = 1'b0;
        wbus.DE_isLoad_i = 1'b0; wbus.DE_wbEnable_i = 1'b0; wbus.DE_rdId_i = 6'd0;
        wbus.aluBusy_i = 1'b0; wbus.E_correctPC_i = 1'b0; wbus.halt_i = 1'b0;
    endtask

    // Advance one edge; inputs are then driven 1 time unit after posedge.
    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    int e_stall_seen;
    int multi_seen;

    initial begin
        idle();
        idle_wd();
        reset_i = 1'b1;
        #2;
        check("reset_ctl", 32'(ctl), 32'b000_111_0);
        next();
        reset_i = 1'b0;
        #1;
        check("reset_state", 32'(bus.state_o), 32'd0);
        check("reset_flags", 32'({bus.halted_o, bus.timeout_o}), 32'd0);
        check("reset_stallcnt", bus.stallCycles_o, 32'd0);
        check("reset_multiops", bus.multiOps_o, 32'd0);

        // Load x5 in execute, add reading x5 in decode.
        bus.DE_isLoad_i = 1'b1; bus.DE_wbEnable_i = 1'b1; bus.DE_rdId_i = 6'd5;
        bus.D_rs2Id_i = 6'd5; bus.D_rs2Used_i = 1'b1;
        #1;
        check("loaduse_ctl", 32'(ctl), 32'b110_010_1);
        next();
        bus.DE_isLoad_i = 1'b0;
        #1;
        check("bubble_ctl", 32'(ctl), 32'd0);
        check("loaduse_nostall", bus.stallCycles_o, 32'd0);

        // x0 never hazards, FP register 0 does, unused source never does.
        bus.DE_isLoad_i = 1'b1; bus.DE_rdId_i = 6'd0; bus.D_rs2Id_i = 6'd0;
        #1;
        check("x0_ctl", 32'(ctl), 32'd0);
        bus.DE_rdId_i = 6'd32; bus.D_rs2Id_i = 6'd0;
        bus.D_rs1Id_i = 6'd32; bus.D_rs1Used_i = 1'b1;
        #1;
        check("f0_ctl", 32'(ctl), 32'b110_010_1);
        bus.D_rs1Used_i = 1'b0;
        #1;
        check("unused_ctl", 32'(ctl), 32'd0);
        bus.D_rs3Id_i = 6'd32; bus.D_rs3Used_i = 1'b1;
        #1;
        check("rs3_ctl", 32'(ctl), 32'b110_010_1);

        // Correction plus hazard: flush wins, no stall.
        bus.E_correctPC_i = 1'b1;
        #1;
        check("corr_hz_ctl", 32'(ctl), 32'b000_110_1);
        next();
        idle();

        // 33-cycle divide.
        e_stall_seen = 0;
        multi_seen = 0;
        bus.aluBusy_i = 1'b1;
        #1;
        check("busy_first_ctl", 32'(ctl), 32'b111_001_0);
        for (int i = 0; i < 33; i++) begin
            if (bus.E_stall_o) e_stall_seen++;
            if (bus.state_o == 2'd1) multi_seen++;
            next();
        end
        bus.aluBusy_i = 1'b0;
        #1;
        if (bus.state_o == 2'd1) multi_seen++;
        check("div_done_ctl", 32'(ctl), 32'd0);
        next();
        check("div_estall_cycles", 32'(e_stall_seen), 32'd33);
        check("div_multi_cycles", 32'(multi_seen), 32'd33);
        check("div_state", 32'(bus.state_o), 32'd0);
        check("div_stallcnt", bus.stallCycles_o, 32'd33);
        check("div_multiops", bus.multiOps_o, 32'd1);

        // halt during a 3-cycle op is deferred until RUN.
        bus.aluBusy_i = 1'b1; bus.halt_i = 1'b1;
        next();
        next();
        next();
        bus.aluBusy_i = 1'b0;
        #1;
        check("halt_defer_state", 32'(bus.state_o), 32'd1);
        check("halt_defer_ctl", 32'(ctl), 32'd0);
        next();
        check("halt_run_state", 32'(bus.state_o), 32'd0);
        check("halt_run_ctl", 32'(ctl), 32'b111_001_0);
        next();
        bus.halt_i = 1'b0; bus.E_correctPC_i = 1'b1;
        #1;
        check("halt_state", 32'(bus.state_o), 32'd2);
        check("halt_flag", 32'(bus.halted_o), 32'd1);
        check("halt_ctl", 32'(ctl), 32'b111_001_0);
        next();
        next();
        check("halt_stay", 32'(bus.state_o), 32'd2);
        check("halt_stallcnt", bus.stallCycles_o, 32'd39);
        check("halt_multiops", bus.multiOps_o, 32'd2);

        // One reset cycle leaves HALT.
        idle();
        reset_i = 1'b1;
        next();
        reset_i = 1'b0;
        #1;
        check("unhalt_state", 32'(bus.state_o), 32'd0);
        check("unhalt_flag", 32'(bus.halted_o), 32'd0);
        check("unhalt_counts", bus.stallCycles_o | bus.multiOps_o, 32'd0);

        // Watchdog with an 8-cycle limit.
        wbus.aluBusy_i = 1'b1;
        for (int i = 0; i < 8; i++) next();
        check("wd_pre_state", 32'(wbus.state_o), 32'd1);
        check("wd_pre_timeout", 32'(wbus.timeout_o), 32'd0);
        next();
        check("wd_timeout", 32'(wbus.timeout_o), 32'd1);
        check("wd_state", 32'(wbus.state_o), 32'd2);
        check("wd_halted", 32'(wbus.halted_o), 32'd1);
        check("wd_stallcnt", wbus.stallCycles_o, 32'd9);
        wbus.aluBusy_i = 1'b0;
        next();
        next();
        check("wd_sticky", 32'({wbus.halted_o, wbus.timeout_o, wbus.state_o}), 32'b1110);

        // Short op, then counter wrap, then reset mid-MULTI.
        bus.aluBusy_i = 1'b1;
        next();
        bus.aluBusy_i = 1'b0;
        next();
        check("short_multiops", bus.multiOps_o, 32'd1);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        #1;
        check("wrap_preload", bus.stallCycles_o, 32'hFFFF_FFFF);
        bus.aluBusy_i = 1'b1;
        next();
        check("wrap_stallcnt", bus.stallCycles_o, 32'd0);
        check("wrap_state", 32'(bus.state_o), 32'd1);
        reset_i = 1'b1;
        #1;
        check("rst_multi_ctl", 32'(ctl), 32'b000_111_0);
        next();
        reset_i = 1'b0;
        bus.aluBusy_i = 1'b0;
        #1;
        check("rst_multi_state", 32'(bus.state_o), 32'd0);
        check("rst_multi_counts", bus.stallCycles_o | bus.multiOps_o, 32'd0);
        check("rst_wd_flags", 32'({wbus.halted_o, wbus.timeout_o, wbus.state_o}), 32'd0);
        check("rst_idle_ctl", 32'(ctl), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Pipeline sequencer for the execute stage. Turns hazard, busy, branch-correction and halt conditions into per-stage stall and flush controls for fetch, decode and execute. Sits beside the execute unit and drives its `E_stall_i` and `M_flush_i` inputs and the decode/fetch pipeline registers. Tracks multi-cycle operations (iterative divide, FPU) with a watchdog, and keeps wrap-around performance counters.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum consecutive cycles in MULTI before the watchdog trips; legal range 2..65535.

Ports:
- `clk_i` input 1: clock; all state updates on the rising edge.
- `reset_i` input 1: reset, synchronous, active-high.
- `D_rs1Id_i`, `D_rs2Id_i`, `D_rs3Id_i` input 6 each: source register IDs of the instruction in decode (bit 5 selects the FP file).
- `D_rs1Used_i`, `D_rs2Used_i`, `D_rs3Used_i` input 1 each: the decode instruction actually reads that source.
- `DE_isLoad_i` input 1: the instruction in execute is a load or AMO.
- `DE_wbEnable_i` input 1: the execute instruction writes back.
- `DE_rdId_i` input 6: destination register of the execute instruction.
- `aluBusy_i` input 1: execute multi-cycle unit busy (combinational from execute).
- `E_correctPC_i` input 1: execute has detected a misprediction this cycle.
- `halt_i` input 1: EBREAK in execute.
- `F_stall_o`, `D_stall_o`, `E_stall_o` output 1 each: hold the fetch PC, the FD register and the DE register.
- `D_flush_o` output 1: load a NOP into FD at the next edge.
- `E_flush_o` output 1: load a NOP into DE at the next edge.
- `M_flush_o` output 1: load a NOP into EM at the next edge.
- `dataHazard_o` output 1: load-use hazard detected this cycle.
- `state_o` output 2: 0 RUN, 1 MULTI, 2 HALT.
- `halted_o` output 1: sticky; set in HALT.
- `timeout_o` output 1: sticky; set when the watchdog trips.
- `stallCycles_o` output 32: count of cycles with `E_stall_o`=1; wraps modulo 2^32.
- `multiOps_o` output 32: count of completed multi-cycle operations; wraps.

## Operation
**Hazard detect (combinational).** `dataHazard_o` = `DE_isLoad_i` & `DE_wbEnable_i` & (`DE_rdId_i`≠0) & any(`Dx_rsNUsed_i` & `DN_rsId`==`DE_rdId_i`). Register 0 (ID 6'd0) never hazards; FP register 0 (ID 6'd32) does.

**RUN**, outputs by priority:
1. `reset_i`: all stalls 0; `D_flush_o`, `E_flush_o`, `M_flush_o` = 1.
2. `halt_i` & !`aluBusy_i`: all stalls 1, `M_flush_o`=1. Next state HALT.
3. `aluBusy_i`: all stalls 1, `M_flush_o`=1, counter loaded with 1. Next state MULTI.
4. `E_correctPC_i`: `D_flush_o`=`E_flush_o`=1, no stalls. Any coincident `dataHazard_o` is ignored for stall purposes, because the decode instruction is squashed.
5. `dataHazard_o`: `F_stall_o`=`D_stall_o`=1, `E_flush_o`=1 (one bubble). `E_stall_o`=0.
6. Otherwise all outputs 0.

**MULTI**:
- While `aluBusy_i`: all stalls 1, `M_flush_o`=1, counter increments.
- When the counter equals `TIMEOUT_CYCLES` with `aluBusy_i` still 1: set `timeout_o` and go to HALT.
- When `aluBusy_i`=0: stalls 0 this cycle so the result advances into EM; `multiOps_o`+1; next state RUN. The RUN priority rules for `E_correctPC_i` and `dataHazard_o` apply in this cycle.

**HALT**:
- Absorbing until reset.
- `F_stall_o`=`D_stall_o`=`E_stall_o`=1 and `M_flush_o`=1 every cycle.
- `halted_o`=1. Inputs are ignored.

**Counters.** `stallCycles_o` increments on every non-reset cycle with `E_stall_o`=1, including every HALT cycle.

## Timing
- Stall, flush and hazard outputs are combinational from the current state and inputs; zero-cycle latency.
- State, sticky flags and counters update on the rising edge.
- Reset values: state RUN; `halted_o` 0; `timeout_o` 0; `stallCycles_o` 0; `multiOps_o` 0; watchdog counter 0.
- Reset wins over everything, including in MULTI and HALT. One reset cycle returns to RUN.
- A load-use hazard costs exactly 1 stall cycle. In the next cycle DE holds the bubble (`DE_isLoad_i`=0), so the hazard clears.
- A multi-cycle op with N busy cycles costs N stall cycles. The result is captured on the first cycle with `aluBusy_i`=0.
- `halt_i` while `aluBusy_i`=1 is deferred until the op completes.

## Test plan
- Load `x5`, then `add` reading `x5`: `DE_rdId_i`=5, `D_rs2Id_i`=5, used → `dataHazard_o`, `F_stall_o`, `D_stall_o`, `E_flush_o` = 1 for 1 cycle. Same with `DE_rdId_i`=0 → no hazard.
- `aluBusy_i` high for 33 cycles (DIV): `state_o`=1 for 33 cycles, `E_stall_o` high for 33 cycles, `stallCycles_o`=33, `multiOps_o`=1, back to RUN.
- `TIMEOUT_CYCLES`=8, `aluBusy_i` held high: `timeout_o`=1 and `state_o`=2 after the 8th MULTI cycle. `halted_o` stays 1 until `reset_i`.
- `E_correctPC_i` and `dataHazard_o` in the same cycle → `D_flush_o`=`E_flush_o`=1, `F_stall_o`=`D_stall_o`=0.
- `halt_i` asserted while `aluBusy_i`=1 for 3 cycles → HALT entered only after busy drops and `halt_i` is seen in RUN.
- Preload `stallCycles_o` near wrap (force 32'hFFFFFFFF) plus 1 stall cycle → 0. `reset_i` asserted mid-MULTI → next cycle RUN, all counters 0.
